// File: rtl/link_capture_ber.sv
// Receive-side link monitor: settles, hunts for frame activity, snapshots the decoded
// stream and counts bit errors against a delayed copy of the transmitted stream.
module link_capture_ber #(
    parameter int unsigned CAP_W      = 8,
    parameter int unsigned SKIP       = 80,
    parameter int unsigned SYNC_ONES  = 6,
    parameter int unsigned SYNC_HITS  = 8,
    parameter int unsigned MAX_DELAY  = 64,
    parameter int unsigned WIN        = 1024,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned AUTO_START = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       bit_en,
    input  logic                       tx_bit,
    input  logic                       rx_bit,
    input  logic [$clog2(MAX_DELAY):0] delay_sel,
    output logic [CAP_W-1:0]           first_result,
    output logic                       capture_done,
    output logic [CNT_W-1:0]           err_count,
    output logic [CNT_W-1:0]           bit_count,
    output logic                       meas_done,
    output logic                       busy
);

    localparam int unsigned DSEL_W    = $clog2(MAX_DELAY) + 1;
    localparam int unsigned PHASE_MAX = (SKIP > SYNC_HITS) ? SKIP : SYNC_HITS;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int unsigned WIN_W     = $clog2(WIN + 1);
    localparam int unsigned POP_W     = $clog2(CAP_W + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWarmup,
        StHunt,
        StMeasure,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [CAP_W-1:0]     rx_win_q, rx_win_d;
    logic [MAX_DELAY-1:0] tx_dly_q, tx_dly_d;
    logic [MAX_DELAY:0]   tx_shift;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [WIN_W-1:0]     meas_cnt_q, meas_cnt_d;
    logic [CNT_W-1:0]     err_q, err_d;
    logic [CNT_W-1:0]     bitc_q, bitc_d;
    logic [CAP_W-1:0]     first_q, first_d;
    logic                 cap_q, cap_d;
    logic                 mdone_q, mdone_d;
    logic                 busy_q, busy_d;
    logic [POP_W-1:0]     ones_cnt;
    logic                 hit;
    logic                 ref_bit;

    // Both history registers run in every state so alignment survives a restart.
    always_comb begin
        tx_shift = {tx_dly_q, tx_bit};
        rx_win_d = rx_win_q;
        tx_dly_d = tx_dly_q;
        if (bit_en) begin
            rx_win_d = {rx_win_q[CAP_W-2:0], rx_bit};
            tx_dly_d = tx_shift[MAX_DELAY-1:0];
        end
    end

    always_comb begin
        ref_bit = tx_bit;
        if (delay_sel >= DSEL_W'(MAX_DELAY)) begin
            ref_bit = tx_dly_q[MAX_DELAY-1];
        end else begin
            for (int unsigned i = 0; i + 1 < MAX_DELAY; i++) begin
                if (delay_sel == DSEL_W'(i + 1)) begin
                    ref_bit = tx_dly_q[i];
                end
            end
        end
    end

    // Hit test looks at the window as it was before this strobe's shift.
    always_comb begin
        ones_cnt = '0;
        for (int unsigned i = 0; i < CAP_W; i++) begin
            ones_cnt = ones_cnt + POP_W'(rx_win_q[i]);
        end
        hit = (ones_cnt >= POP_W'(SYNC_ONES));
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        meas_cnt_d = meas_cnt_q;
        err_d      = err_q;
        bitc_d     = bitc_q;
        first_d    = first_q;
        cap_d      = cap_q;
        mdone_d    = mdone_q;
        if (start) begin
            state_d    = StWarmup;
            phase_d    = '0;
            meas_cnt_d = '0;
            err_d      = '0;
            bitc_d     = '0;
            first_d    = '0;
            cap_d      = 1'b0;
            mdone_d    = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (AUTO_START != 0) begin
                        state_d = StWarmup;
                    end
                end
                StWarmup: begin
                    if (bit_en) begin
                        if (phase_q == PHASE_W'(SKIP - 1)) begin
                            state_d = StHunt;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end
                StHunt: begin
                    if (bit_en && hit) begin
                        if (phase_q == PHASE_W'(SYNC_HITS - 1)) begin
                            first_d = rx_win_d;
                            cap_d   = 1'b1;
                            phase_d = '0;
                            state_d = StMeasure;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end
                StMeasure: begin
                    if (bit_en) begin
                        meas_cnt_d = meas_cnt_q + 1'b1;
                        if (bitc_q != {CNT_W{1'b1}}) begin
                            bitc_d = bitc_q + 1'b1;
                        end
                        if ((rx_bit != ref_bit) && (err_q != {CNT_W{1'b1}})) begin
                            err_d = err_q + 1'b1;
                        end
                        if (meas_cnt_q == WIN_W'(WIN - 1)) begin
                            mdone_d = 1'b1;
                            state_d = StDone;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        busy_d = (state_d == StWarmup) || (state_d == StHunt) || (state_d == StMeasure);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            rx_win_q   <= '0;
            tx_dly_q   <= '0;
            phase_q    <= '0;
            meas_cnt_q <= '0;
            err_q      <= '0;
            bitc_q     <= '0;
            first_q    <= '0;
            cap_q      <= 1'b0;
            mdone_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_win_q   <= rx_win_d;
            tx_dly_q   <= tx_dly_d;
            phase_q    <= phase_d;
            meas_cnt_q <= meas_cnt_d;
            err_q      <= err_d;
            bitc_q     <= bitc_d;
            first_q    <= first_d;
            cap_q      <= cap_d;
            mdone_q    <= mdone_d;
            busy_q     <= busy_d;
        end
    end

    assign first_result = first_q;
    assign capture_done = cap_q;
    assign err_count    = err_q;
    assign bit_count    = bitc_q;
    assign meas_done    = mdone_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_link_capture_ber.sv
// Directed bench for link_capture_ber: default, small-counter and manual-start instances.
module tb_link_capture_ber;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a = 1'b0, reset_s = 1'b0, reset_m = 1'b0;
    logic       start_a = 1'b0, start_s = 1'b0, start_m = 1'b0;
    logic       bit_en = 1'b0, tx_bit = 1'b0, rx_bit = 1'b0;
    logic [6:0] delay_sel = '0;

    logic [7:0]  fr_a, fr_s, fr_m;
    logic        cd_a, cd_s, cd_m, md_a, md_s, md_m, busy_a, busy_s, busy_m;
    logic [15:0] ec_a, bc_a, ec_m, bc_m;
    logic [3:0]  ec_s, bc_s;

    int total = 0;
    int bad   = 0;

    logic [63:0] hist = '0;       // bench copy of the tx history seen by the main instance
    logic [15:0] lfsr = 16'hACE1;

    link_capture_ber dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .bit_en(bit_en), .tx_bit(tx_bit),
        .rx_bit(rx_bit), .delay_sel(delay_sel), .first_result(fr_a), .capture_done(cd_a),
        .err_count(ec_a), .bit_count(bc_a), .meas_done(md_a), .busy(busy_a)
    );

    link_capture_ber #(.CNT_W(4), .WIN(32)) dut_s (
        .clk(clk), .reset(reset_s), .start(start_s), .bit_en(bit_en), .tx_bit(tx_bit),
        .rx_bit(rx_bit), .delay_sel(delay_sel), .first_result(fr_s), .capture_done(cd_s),
        .err_count(ec_s), .bit_count(bc_s), .meas_done(md_s), .busy(busy_s)
    );

    link_capture_ber #(.AUTO_START(0)) dut_m (
        .clk(clk), .reset(reset_m), .start(start_m), .bit_en(bit_en), .tx_bit(tx_bit),
        .rx_bit(rx_bit), .delay_sel(delay_sel), .first_result(fr_m), .capture_done(cd_m),
        .err_count(ec_m), .bit_count(bc_m), .meas_done(md_m), .busy(busy_m)
    );

    task automatic strobe(input logic rx, input logic tx);
        @(negedge clk);
        bit_en = 1'b1;
        rx_bit = rx;
        tx_bit = tx;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        hist = {hist[62:0], tx};
    endtask

    task automatic ones(input int n);
        repeat (n) strobe(1'b1, 1'b1);
    endtask

    task automatic lfsr_bit(output logic b);
        logic fb;
        b = lfsr[0];
        fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
        lfsr = {fb, lfsr[15:1]};
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({fr_a, cd_a, ec_a, bc_a, md_a, busy_a} !== '0) begin
            bad++;
            $display("FAIL reset_state: got fr=%h cd=%b ec=%0d bc=%0d md=%b busy=%b want all 0",
                     fr_a, cd_a, ec_a, bc_a, md_a, busy_a);
        end
        @(negedge clk);
        reset_a = 1'b1;
        reset_s = 1'b1;
        reset_m = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (busy_a !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_1clk: got %b want 1", busy_a);
        end
    endtask

    task automatic test_capture();
        ones(87);
        total++;
        if (cd_a !== 1'b0) begin
            bad++;
            $display("FAIL capture_early: got cd=%b want 0 after 87 strobes", cd_a);
        end
        ones(1);
        total++;
        if (cd_a !== 1'b1 || fr_a !== 8'hFF) begin
            bad++;
            $display("FAIL capture_88: got cd=%b fr=%h want cd=1 fr=ff", cd_a, fr_a);
        end
        total++;
        if (bc_a !== 16'd0 || busy_a !== 1'b1) begin
            bad++;
            $display("FAIL capture_state: got bc=%0d busy=%b want 0/1", bc_a, busy_a);
        end
    endtask

    // rx is always tx delayed by 5; dsel selects the DUT's alignment.
    task automatic run_window(input logic [6:0] dsel, input bit inject, input int exp_err,
                              input string name);
        int   mdl;
        int   want;
        logic t, r;
        delay_sel = dsel;
        pulse_start_a();
        ones(88);
        total++;
        if (cd_a !== 1'b1) begin
            bad++;
            $display("FAIL %s_capture: got cd=%b want 1", name, cd_a);
        end
        mdl = 0;
        for (int k = 0; k < 1024; k++) begin
            lfsr_bit(t);
            r = hist[4];
            if (inject && (k % 8 == 7)) r = ~r;
            if (r != hist[dsel-1]) mdl++;
            strobe(r, t);
            if (k == 1022) begin
                total++;
                if (md_a !== 1'b0 || bc_a !== 16'd1023) begin
                    bad++;
                    $display("FAIL %s_pre_done: got md=%b bc=%0d want 0/1023", name, md_a, bc_a);
                end
            end
        end
        want = (exp_err < 0) ? mdl : exp_err;
        total++;
        if (md_a !== 1'b1 || bc_a !== 16'd1024 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL %s_done: got md=%b bc=%0d busy=%b want 1/1024/0",
                     name, md_a, bc_a, busy_a);
        end
        total++;
        if (ec_a !== 16'(want)) begin
            bad++;
            $display("FAIL %s_err: got %0d want %0d", name, ec_a, want);
        end
        strobe(1'b0, 1'b1);
        strobe(1'b1, 1'b0);
        total++;
        if (ec_a !== 16'(want) || bc_a !== 16'd1024 || md_a !== 1'b1) begin
            bad++;
            $display("FAIL %s_hold: got ec=%0d bc=%0d md=%b want %0d/1024/1",
                     name, ec_a, bc_a, md_a, want);
        end
    endtask

    task automatic test_windows();
        run_window(7'd5, 1'b0, 0, "aligned");
        run_window(7'd5, 1'b1, 128, "inject8");
        run_window(7'd4, 1'b0, -1, "misalign");
    endtask

    task automatic test_saturate();
        delay_sel = 7'd0;
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        ones(88);
        repeat (15) strobe(1'b0, 1'b1);
        total++;
        if (ec_s !== 4'd15 || bc_s !== 4'd15) begin
            bad++;
            $display("FAIL sat_15: got ec=%0d bc=%0d want 15/15", ec_s, bc_s);
        end
        repeat (16) strobe(1'b0, 1'b1);
        total++;
        if (ec_s !== 4'd15 || bc_s !== 4'd15 || md_s !== 1'b0) begin
            bad++;
            $display("FAIL sat_31: got ec=%0d bc=%0d md=%b want 15/15/0", ec_s, bc_s, md_s);
        end
        strobe(1'b0, 1'b1);
        total++;
        if (ec_s !== 4'd15 || bc_s !== 4'd15 || md_s !== 1'b1 || busy_s !== 1'b0) begin
            bad++;
            $display("FAIL sat_32: got ec=%0d bc=%0d md=%b busy=%b want 15/15/1/0",
                     ec_s, bc_s, md_s, busy_s);
        end
        #2;
        reset_s = 1'b0;
        #1;
        total++;
        if ({ec_s, bc_s, md_s, cd_s, fr_s} !== '0) begin
            bad++;
            $display("FAIL sat_async_reset: got ec=%0d bc=%0d md=%b cd=%b fr=%h want 0",
                     ec_s, bc_s, md_s, cd_s, fr_s);
        end
        reset_s = 1'b1;
    endtask

    task automatic test_start_mid();
        delay_sel = 7'd0;
        pulse_start_a();
        ones(88);
        repeat (10) strobe(1'b0, 1'b1);
        total++;
        if (ec_a !== 16'd10 || bc_a !== 16'd10) begin
            bad++;
            $display("FAIL mid_count: got ec=%0d bc=%0d want 10/10", ec_a, bc_a);
        end
        @(negedge clk);
        bit_en  = 1'b1;
        rx_bit  = 1'b0;
        tx_bit  = 1'b1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        bit_en  = 1'b0;
        start_a = 1'b0;
        hist = {hist[62:0], 1'b1};
        total++;
        if ({ec_a, bc_a, cd_a, md_a, fr_a} !== '0 || busy_a !== 1'b1) begin
            bad++;
            $display("FAIL start_clear: got ec=%0d bc=%0d cd=%b md=%b fr=%h busy=%b want 0,busy 1",
                     ec_a, bc_a, cd_a, md_a, fr_a, busy_a);
        end
        ones(87);
        total++;
        if (cd_a !== 1'b0) begin
            bad++;
            $display("FAIL start_strobe_counted: got cd=%b want 0 after 87", cd_a);
        end
        ones(1);
        total++;
        if (cd_a !== 1'b1) begin
            bad++;
            $display("FAIL start_recapture: got cd=%b want 1 after 88", cd_a);
        end
    endtask

    task automatic test_reset_hunt();
        pulse_start_a();
        ones(84);
        #2;
        reset_a = 1'b0;
        #1;
        total++;
        if (busy_a !== 1'b0 || {ec_a, bc_a, cd_a, md_a, fr_a} !== '0) begin
            bad++;
            $display("FAIL hunt_async_reset: got busy=%b cd=%b want 0", busy_a, cd_a);
        end
        reset_a = 1'b1;
        // Manual-start instance: start under reset is ignored, then idles until start.
        @(negedge clk);
        reset_m = 1'b0;
        start_m = 1'b1;
        @(posedge clk);
        #1;
        start_m = 1'b0;
        @(negedge clk);
        reset_m = 1'b1;
        repeat (5) @(posedge clk);
        ones(3);
        total++;
        if (busy_m !== 1'b0) begin
            bad++;
            $display("FAIL manual_idle: got busy=%b want 0", busy_m);
        end
        @(negedge clk);
        start_m = 1'b1;
        @(posedge clk);
        #1;
        start_m = 1'b0;
        total++;
        if (busy_m !== 1'b1) begin
            bad++;
            $display("FAIL manual_start: got busy=%b want 1", busy_m);
        end
        ones(88);
        total++;
        if (cd_m !== 1'b1 || fr_m !== 8'hFF) begin
            bad++;
            $display("FAIL manual_capture: got cd=%b fr=%h want 1/ff", cd_m, fr_m);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_windows();
        test_saturate();
        test_start_mid();
        test_reset_hunt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
